// File: rtl/chip8_audio_pkg.sv
// chip8_audio_pkg: shared types, constants and the waveform shaper used by
// the CHIP-8 multi-voice audio synthesiser.
//
// Contents:
//   timbre_t    - voice timbre selector (square, triangle, saw, noise)
//   LFSR_W      - noise LFSR width
//   LFSR_SEED   - noise LFSR reset value
//   SAMPLE_W    - signed audio sample width
//   ENV_W       - envelope register width
//   ENV_MAX     - envelope full-scale value
//   wave_shape  - maps the top phase byte (or noise bit) to a signed sample

package chip8_audio_pkg;

    typedef enum logic [1:0] {
        TIMBRE_SQUARE   = 2'd0,
        TIMBRE_TRIANGLE = 2'd1,
        TIMBRE_SAW      = 2'd2,
        TIMBRE_NOISE    = 2'd3
    } timbre_t;

    localparam int unsigned LFSR_W    = 15;
    localparam logic [14:0] LFSR_SEED = 15'h0001;
    localparam int unsigned SAMPLE_W  = 8;
    localparam int unsigned ENV_W     = 8;
    localparam int          ENV_MAX   = 255;

    // Returns the raw two's-complement bit pattern of the waveform sample.
    function automatic logic [7:0] wave_shape(input timbre_t    timbre,
                                              input logic [7:0] p,
                                              input logic       noise_bit);
        logic [6:0] tri_v;
        logic [7:0] result;
        tri_v  = p[7] ? ~p[6:0] : p[6:0];
        result = 8'h00;
        case (timbre)
            TIMBRE_SQUARE:   result = p[7] ? 8'h80 : 8'h7F;
            TIMBRE_TRIANGLE: result = {tri_v, 1'b0} - 8'h80;
            TIMBRE_SAW:      result = {~p[7], p[6:0]};
            TIMBRE_NOISE:    result = noise_bit ? 8'h7F : 8'h80;
            default:         result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/chip8_audio_voice.sv
// chip8_audio_voice: one synthesiser voice. Holds the phase accumulator, noise
// LFSR and envelope, and produces a registered, envelope- and volume-scaled
// signed 8-bit sample.
//
// Configuration macro: CHIP8_AUDIO_ENVELOPE_EN
//   defined   - envelope ramps up by ATTACK_STEP / down by RELEASE_STEP per sample
//   undefined - envelope snaps to ENV_MAX / 0 on each sample; steps are ignored
//
// Ports:
//   clk_in          - system clock
//   rst_in          - synchronous active-high reset
//   sample_valid_in - one-cycle strobe; all inputs are sampled only here
//   active_in       - note gate
//   timbre_in       - timbre select (see timbre_t)
//   tone_in         - phase increment per sample
//   vol_in          - volume 0..7 (7 = full scale)
//   voice_out       - registered signed voice sample

module chip8_audio_voice
    import chip8_audio_pkg::*;
#(
    parameter int unsigned PHASE_W      = 16,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned RELEASE_STEP = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       sample_valid_in,
    input  logic                       active_in,
    input  logic [1:0]                 timbre_in,
    input  logic [PHASE_W-1:0]         tone_in,
    input  logic [2:0]                 vol_in,
    output logic signed [SAMPLE_W-1:0] voice_out
);

    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [LFSR_W-1:0]          lfsr_q, lfsr_d;
    logic [ENV_W-1:0]           env_q, env_d;
    timbre_t                    timbre_q, timbre_d;
    logic [2:0]                 vol_q, vol_d;
    logic signed [SAMPLE_W-1:0] voice_q, voice_d;

    logic [PHASE_W:0]           phase_sum;
    logic                       wrap;
    logic [ENV_W-1:0]           env_next;

    logic signed [SAMPLE_W-1:0] wave;
    logic signed [SAMPLE_W-1:0] scaled;
    logic signed [17:0]         wave_ext;
    logic signed [17:0]         env_ext;
    logic signed [17:0]         prod;

`ifdef CHIP8_AUDIO_ENVELOPE_EN
    int env_tmp;

    always_comb begin
        env_tmp = 0;
        if (active_in) begin
            env_tmp = int'(env_q) + int'(ATTACK_STEP);
            if (env_tmp > ENV_MAX) begin
                env_tmp = ENV_MAX;
            end
        end else begin
            env_tmp = int'(env_q) - int'(RELEASE_STEP);
            if (env_tmp < 0) begin
                env_tmp = 0;
            end
        end
        env_next = ENV_W'(env_tmp);
    end
`else
    // Ramp steps only matter when the envelope is enabled.
    logic unused_env_steps;
    assign unused_env_steps = ^{32'(ATTACK_STEP), 32'(RELEASE_STEP)};

    always_comb begin
        env_next = active_in ? ENV_W'(ENV_MAX) : '0;
    end
`endif

    // Per-sample state update.
    always_comb begin
        phase_sum = {1'b0, phase_q} + {1'b0, tone_in};
        wrap      = phase_sum[PHASE_W];
        phase_d   = phase_q;
        lfsr_d    = lfsr_q;
        env_d     = env_q;
        timbre_d  = timbre_q;
        vol_d     = vol_q;
        if (sample_valid_in) begin
            phase_d = phase_sum[PHASE_W-1:0];
            if (wrap) begin
                lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};
            end
            env_d = env_next;
            // A fully released voice restarts its next note at phase 0.
            if (!active_in && (env_next == '0)) begin
                phase_d = '0;
            end
            timbre_d = timbre_t'(timbre_in);
            vol_d    = vol_in;
        end
    end

    // Waveform and scaling; output is registered one cycle after the state.
    always_comb begin
        wave     = $signed(wave_shape(timbre_q, phase_q[PHASE_W-1 -: 8], lfsr_q[0]));
        wave_ext = 18'(wave);
        env_ext  = 18'({1'b0, env_q}) + 18'd1;
        prod     = wave_ext * env_ext;
        scaled   = (env_q == '0) ? '0 : SAMPLE_W'(prod >>> 8);
        // ~vol is 7-vol for a 3-bit volume.
        voice_d  = scaled >>> (~vol_q);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            env_q    <= '0;
            timbre_q <= TIMBRE_SQUARE;
            vol_q    <= '0;
            voice_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            env_q    <= env_d;
            timbre_q <= timbre_d;
            vol_q    <= vol_d;
            voice_q  <= voice_d;
        end
    end

    assign voice_out = voice_q;

endmodule

// File: rtl/chip8_audio_synth.sv
// chip8_audio_synth: NUM_CH-voice CHIP-8 audio synthesiser. Generates the PDM
// and sample ticks, mixes and saturates the voice samples, and drives a
// first-order sigma-delta modulator onto a 1-bit PDM output.
//
// Configuration macro: CHIP8_AUDIO_ENVELOPE_EN (attack/release ramp in voices)
//
// Ports:
//   clk_in    - system clock
//   rst_in    - synchronous active-high reset
//   active_in - per-voice gate, bit c = voice c
//   timbre_in - voice c uses [2c+:2]
//   tone_in   - voice c uses [PHASE_W*c+:PHASE_W]
//   vol_in    - voice c uses [3c+:3]
//   level_out - registered PDM bit

module chip8_audio_synth
    import chip8_audio_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned PHASE_W      = 16,
    parameter int unsigned CLK_DIV      = 32,
    parameter int unsigned SAMPLE_DIV   = 1024,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned RELEASE_STEP = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_CH-1:0]           active_in,
    input  logic [2*NUM_CH-1:0]         timbre_in,
    input  logic [PHASE_W*NUM_CH-1:0]   tone_in,
    input  logic [3*NUM_CH-1:0]         vol_in,
    output logic                        level_out
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned SMP_W = $clog2(SAMPLE_DIV);
    localparam int unsigned SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;

    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-128);

    logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
    logic [SMP_W-1:0]           smp_cnt_q, smp_cnt_d;
    logic signed [SAMPLE_W-1:0] sample_reg_q, sample_reg_d;
    logic [7:0]                 acc_q, acc_d;
    logic                       level_q, level_d;

    logic                       tick;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] voice_val [NUM_CH];
    logic signed [SUM_W-1:0]    mix_sum;
    logic [7:0]                 pdm_u;
    logic [8:0]                 pdm_sum;

    // Tick generation.
    always_comb begin
        tick         = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        sample_valid = tick && (smp_cnt_q == SMP_W'(SAMPLE_DIV - 1));
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        smp_cnt_d    = smp_cnt_q;
        if (tick) begin
            smp_cnt_d = sample_valid ? '0 : smp_cnt_q + SMP_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_voice
        chip8_audio_voice #(
            .PHASE_W      (PHASE_W),
            .ATTACK_STEP  (ATTACK_STEP),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_voice (
            .clk_in          (clk_in),
            .rst_in          (rst_in),
            .sample_valid_in (sample_valid),
            .active_in       (active_in[c]),
            .timbre_in       (timbre_in[2*c +: 2]),
            .tone_in         (tone_in[PHASE_W*c +: PHASE_W]),
            .vol_in          (vol_in[3*c +: 3]),
            .voice_out       (voice_val[c])
        );
    end

    // Mixer with saturation; the sum is wide enough that it cannot overflow.
    always_comb begin
        mix_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mix_sum = mix_sum + SUM_W'(voice_val[c]);
        end
        if (mix_sum > SAT_HI) begin
            sample_reg_d = 8'sd127;
        end else if (mix_sum < SAT_LO) begin
            sample_reg_d = -8'sd128;
        end else begin
            sample_reg_d = mix_sum[SAMPLE_W-1:0];
        end
    end

    // First-order sigma-delta: the accumulator carry is the PDM bit.
    always_comb begin
        pdm_u   = {~sample_reg_q[7], sample_reg_q[6:0]};
        pdm_sum = {1'b0, acc_q} + {1'b0, pdm_u};
        acc_d   = acc_q;
        level_d = level_q;
        if (tick) begin
            acc_d   = pdm_sum[7:0];
            level_d = pdm_sum[8];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            sample_reg_q <= '0;
            acc_q        <= '0;
            level_q      <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            sample_reg_q <= sample_reg_d;
            acc_q        <= acc_d;
            level_q      <= level_d;
        end
    end

    assign level_out = level_q;

endmodule

// File: tb/tb_chip8_audio_synth.sv
// tb_chip8_audio_synth: directed self-checking bench for chip8_audio_synth with
// NUM_CH=2, PHASE_W=16, CLK_DIV=4, SAMPLE_DIV=4. Expected values are
// hand-computed; both settings of CHIP8_AUDIO_ENVELOPE_EN are covered.
//
// Cycle k is the clock period ending with the k-th rising edge after reset
// release. Sample k is strobed in cycle 15+16k, its state is visible in cycle
// 16+16k and the mixed sample in cycle 18+16k.

module tb_chip8_audio_synth;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [1:0]  active_in = '0;
    logic [3:0]  timbre_in = '0;
    logic [31:0] tone_in = '0;
    logic [5:0]  vol_in = '0;
    logic        level_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    chip8_audio_synth #(
        .NUM_CH       (2),
        .PHASE_W      (16),
        .CLK_DIV      (4),
        .SAMPLE_DIV   (4),
        .ATTACK_STEP  (16),
        .RELEASE_STEP (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .active_in (active_in),
        .timbre_in (timbre_in),
        .tone_in   (tone_in),
        .vol_in    (vol_in),
        .level_out (level_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
    endtask

    // One-cycle reset pulse; returns at the start of cycle 0.
    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        cyc = 0;
    endtask

    task automatic check_sample(input string tag, input int k, input int exp);
        goto(18 + 16 * k);
        check(tag, $signed(dut.sample_reg_q), exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"}, level_out, 0);
        check({tag, "_sample"}, $signed(dut.sample_reg_q), 0);
        check({tag, "_div"}, dut.div_cnt_q, 0);
        check({tag, "_smp"}, dut.smp_cnt_q, 0);
        check({tag, "_phase"}, dut.gen_voice[0].u_voice.phase_q, 0);
        check({tag, "_env"}, dut.gen_voice[0].u_voice.env_q, 0);
        check({tag, "_lfsr"}, dut.gen_voice[0].u_voice.lfsr_q, 1);
    endtask

`ifdef CHIP8_AUDIO_ENVELOPE_EN
    int exp_sq  [3] = '{-9, 16, -25};
    int exp_mix [4] = '{-3, 20, -8, -25};
    int exp_sat [7] = '{12, 16, 12, 0, -22, -50, -86};
    int exp_nz  [3] = '{8, -17, -25};
`else
    int exp_sq  [3] = '{-128, 127, -128};
    int exp_mix [4] = '{-32, 127, -34, -97};
    int exp_sat [7] = '{127, 127, 64, 0, -64, -128, -128};
    int exp_nz  [3] = '{127, -128, -128};
`endif

    initial begin
        // Silence: u=128 makes the PDM bit alternate 0,1 on successive ticks.
        active_in = 2'b00;
        do_reset();
        check_reset_state("reset");
        goto(4);  check("silence_lvl_t0", level_out, 0);
        goto(7);  check("silence_lvl_hold", level_out, 0);
        goto(8);  check("silence_lvl_t1", level_out, 1);
        goto(12); check("silence_lvl_t2", level_out, 0);
        goto(16); check("silence_lvl_t3", level_out, 1);
        check_sample("silence_sample", 0, 0);

        // Square on voice 0, full volume, half-rate tone.
        active_in = 2'b01;
        timbre_in = {2'd0, 2'd0};
        tone_in   = {16'h0000, 16'h8000};
        vol_in    = {3'd0, 3'd7};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check_sample($sformatf("square_s%0d", k), k, exp_sq[k]);
        end

        // Reset pulse mid-tone, then the first tick must land in cycle 3.
        goto(60);
        do_reset();
        check_reset_state("midreset");
        goto(7); check("midreset_lvl_c7", level_out, 0);
        goto(8); check("midreset_lvl_c8", level_out, 1);

        // Triangle (vol 7) mixed with quieter square (vol 5).
        active_in = 2'b11;
        timbre_in = {2'd0, 2'd1};
        tone_in   = {16'h8000, 16'h4000};
        vol_in    = {3'd5, 3'd7};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check_sample($sformatf("mix_s%0d", k), k, exp_mix[k]);
        end

        // Two saws: positive and negative saturation.
        active_in = 2'b11;
        timbre_in = {2'd2, 2'd2};
        tone_in   = {16'hE000, 16'hE000};
        vol_in    = {3'd7, 3'd7};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            check_sample($sformatf("sat_s%0d", k), k, exp_sat[k]);
        end

        // Noise: LFSR steps only on phase wrap (every 2nd sample).
        active_in = 2'b01;
        timbre_in = {2'd0, 2'd3};
        tone_in   = {16'h0000, 16'h8000};
        vol_in    = {3'd0, 3'd7};
        do_reset();
        goto(16); check("noise_lfsr_s0", dut.gen_voice[0].u_voice.lfsr_q, 1);
        check_sample("noise_s0", 0, exp_nz[0]);
        goto(32); check("noise_lfsr_s1", dut.gen_voice[0].u_voice.lfsr_q, 2);
        check_sample("noise_s1", 1, exp_nz[1]);
        goto(48); check("noise_lfsr_s2", dut.gen_voice[0].u_voice.lfsr_q, 2);
        check_sample("noise_s2", 2, exp_nz[2]);
        goto(64); check("noise_lfsr_s3", dut.gen_voice[0].u_voice.lfsr_q, 4);

        // Envelope attack/release and phase restart after full release.
        active_in = 2'b01;
        timbre_in = {2'd0, 2'd0};
        tone_in   = {16'h0000, 16'h0300};
        vol_in    = {3'd0, 3'd7};
        do_reset();
`ifdef CHIP8_AUDIO_ENVELOPE_EN
        goto(16);  check("env_att_s0", dut.gen_voice[0].u_voice.env_q, 16);
        goto(240); check("env_att_s14", dut.gen_voice[0].u_voice.env_q, 240);
        goto(256); check("env_att_s15", dut.gen_voice[0].u_voice.env_q, 255);
        goto(260); active_in = 2'b00;
        goto(272); check("env_rel_s16", dut.gen_voice[0].u_voice.env_q, 251);
        goto(1264);
        check("env_rel_s78", dut.gen_voice[0].u_voice.env_q, 3);
        check("env_rel_phase_s78", dut.gen_voice[0].u_voice.phase_q, 32'hED00);
        check_sample("env_rel_sample_s78", 78, -2);
        goto(1280);
        check("env_rel_s79", dut.gen_voice[0].u_voice.env_q, 0);
        check("env_rel_phase_s79", dut.gen_voice[0].u_voice.phase_q, 0);
        check_sample("env_rel_sample_s79", 79, 0);
`else
        goto(16);
        check("env_on_s0", dut.gen_voice[0].u_voice.env_q, 255);
        check("env_on_phase_s0", dut.gen_voice[0].u_voice.phase_q, 32'h0300);
        check_sample("env_on_sample_s0", 0, 127);
        goto(20); active_in = 2'b00;
        goto(32);
        check("env_off_s1", dut.gen_voice[0].u_voice.env_q, 0);
        check("env_off_phase_s1", dut.gen_voice[0].u_voice.phase_q, 0);
        check_sample("env_off_sample_s1", 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
